// File: rtl/issue_hazard_ctrl.sv
// rtl/issue_hazard_ctrl.sv - single-entry issue buffer with RAW hazard detection, load-use stall and forwarding selects
module issue_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_instr_valid,
   input  logic [31:0]      i_instr,
   output logic             o_instr_ready,
   output logic             o_issue_valid,
   input  logic             i_issue_ready,
   output logic [31:0]      o_issue_instr,
   output logic [4:0]       o_rs1,
   output logic [4:0]       o_rs2,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   input  logic             i_flush,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_EX  = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             valid_q;
   logic [31:0]      instr_q;
   logic [CNT_W-1:0] stall_q;

   // EX/MEM shadows track what the datapath holds, so only the fields hazards need
   logic             ex_valid_q, ex_load_q, ex_wr_q;
   logic [4:0]       ex_rd_q;
   logic             mem_valid_q, mem_wr_q;
   logic [4:0]       mem_rd_q;

   logic [6:0]       opcode;
   logic [4:0]       rd, rs1, rs2;
   logic             uses_rs1, uses_rs2, wr_class, is_load, writes_rd;
   logic             load_use, accept, issue_fire;

   assign opcode = instr_q[6:0];
   assign rd     = instr_q[11:7];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      wr_class = 1'b0;
      is_load  = 1'b0;
      case (opcode)
         OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; wr_class = 1'b1; end
         OP_IALU:   begin uses_rs1 = 1'b1; wr_class = 1'b1; end
         OP_LOAD:   begin uses_rs1 = 1'b1; wr_class = 1'b1; is_load = 1'b1; end
         OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_JALR:   begin uses_rs1 = 1'b1; wr_class = 1'b1; end
         OP_JAL, OP_LUI, OP_AUIPC: wr_class = 1'b1;
         default: ;
      endcase
   end

   assign writes_rd = wr_class && (rd != 5'd0);

   assign o_rs1 = uses_rs1 ? rs1 : 5'd0;
   assign o_rs2 = uses_rs2 ? rs2 : 5'd0;

   // o_rs1/o_rs2 are already zero for unused operands, and x0 never forwards
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic ex_hit, input logic mem_hit);
      if (rs == 5'd0) return SEL_RF;
      if (ex_hit)     return SEL_EX;
      if (mem_hit)    return SEL_MEM;
      return SEL_RF;
   endfunction

   assign o_fwd_a = fwd_sel(o_rs1, ex_valid_q && ex_wr_q && (ex_rd_q == o_rs1),
                            mem_valid_q && mem_wr_q && (mem_rd_q == o_rs1));
   assign o_fwd_b = fwd_sel(o_rs2, ex_valid_q && ex_wr_q && (ex_rd_q == o_rs2),
                            mem_valid_q && mem_wr_q && (mem_rd_q == o_rs2));

   assign load_use = ex_valid_q && ex_load_q && (ex_rd_q != 5'd0) &&
                     ((uses_rs1 && (rs1 == ex_rd_q)) || (uses_rs2 && (rs2 == ex_rd_q)));

   assign o_issue_valid = valid_q && !load_use && !i_flush;
   assign issue_fire    = o_issue_valid && i_issue_ready;
   assign o_instr_ready = !i_flush && (!valid_q || issue_fire);
   assign accept        = i_instr_valid && o_instr_ready;
   assign o_issue_instr = instr_q;
   assign o_stall_cnt   = stall_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         valid_q     <= 1'b0;
         instr_q     <= 32'd0;
         stall_q     <= '0;
         ex_valid_q  <= 1'b0;
         ex_load_q   <= 1'b0;
         ex_wr_q     <= 1'b0;
         ex_rd_q     <= 5'd0;
         mem_valid_q <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 5'd0;
      end else begin
         if (i_flush) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b1;
            instr_q <= i_instr;
         end else if (issue_fire) begin
            valid_q <= 1'b0;
         end

         // A stalled or flushed cycle pushes a bubble into EX
         if (i_issue_ready) begin
            mem_valid_q <= ex_valid_q;
            mem_wr_q    <= ex_wr_q;
            mem_rd_q    <= ex_rd_q;
            ex_valid_q  <= issue_fire;
            ex_load_q   <= issue_fire && is_load;
            ex_wr_q     <= issue_fire && writes_rd;
            ex_rd_q     <= issue_fire ? rd : 5'd0;
         end

         if (valid_q && load_use && !i_flush && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb/tb_issue_hazard_ctrl.sv - directed scoreboard bench for issue_hazard_ctrl
module tb_issue_hazard_ctrl;

   localparam logic [31:0] ADD3  = 32'h002081B3;  // add  x3,x1,x2
   localparam logic [31:0] SUB4  = 32'h40118233;  // sub  x4,x3,x1
   localparam logic [31:0] ADDI8 = 32'h00500413;  // addi x8,x0,5
   localparam logic [31:0] LW5   = 32'h0000A283;  // lw   x5,0(x1)
   localparam logic [31:0] ADD6  = 32'h00228333;  // add  x6,x5,x2
   localparam logic [31:0] ADDI0 = 32'h00100013;  // addi x0,x0,1
   localparam logic [31:0] ADD7  = 32'h000003B3;  // add  x7,x0,x0

   typedef struct packed {
      logic [31:0] instr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [1:0]  fa;
      logic [1:0]  fb;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_instr_valid;
   logic [31:0] i_instr;
   logic        o_instr_ready;
   logic        o_issue_valid;
   logic        i_issue_ready;
   logic [31:0] o_issue_instr;
   logic [4:0]  o_rs1, o_rs2;
   logic [1:0]  o_fwd_a, o_fwd_b;
   logic        i_flush;
   logic [15:0] o_stall_cnt;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   exp_stall;

   always #5 i_clk = ~i_clk;

   issue_hazard_ctrl #(.CNT_W(16)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_instr_valid(i_instr_valid), .i_instr(i_instr), .o_instr_ready(o_instr_ready),
      .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
      .o_issue_instr(o_issue_instr), .o_rs1(o_rs1), .o_rs2(o_rs2),
      .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .i_flush(i_flush), .o_stall_cnt(o_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_instr_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input logic [31:0] ins, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      logic rdy;
      int   n;
      e.instr = ins; e.rs1 = r1; e.rs2 = r2; e.fa = fa; e.fb = fb;
      exp_q.push_back(e);
      i_instr_valid = 1'b1;
      i_instr = ins;
      n = 0;
      do begin
         @(negedge i_clk);
         rdy = o_instr_ready;
         tick();
         n++;
      end while (!rdy && n < 20);
      chk("accept", {31'd0, rdy}, 32'd1);
      i_instr_valid = 1'b0;
   endtask

   // Scoreboard: every issue handshake pops the oldest expected instruction
   always @(negedge i_clk) begin
      if (i_rstn === 1'b1 && o_issue_valid === 1'b1 && i_issue_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_issue observed %0h expected none", o_issue_instr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("issue_instr", o_issue_instr, mon_e.instr);
            chk("issue_rs1", {27'd0, o_rs1}, {27'd0, mon_e.rs1});
            chk("issue_rs2", {27'd0, o_rs2}, {27'd0, mon_e.rs2});
            chk("issue_fwd_a", {30'd0, o_fwd_a}, {30'd0, mon_e.fa});
            chk("issue_fwd_b", {30'd0, o_fwd_b}, {30'd0, mon_e.fb});
         end
      end
   end

   initial begin
      i_rstn = 1'b0; i_instr_valid = 1'b0; i_instr = 32'd0;
      i_issue_ready = 1'b1; i_flush = 1'b0; exp_stall = 0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_issue_valid", {31'd0, o_issue_valid}, 32'd0);
      chk("rst_instr_ready", {31'd0, o_instr_ready}, 32'd1);
      chk("rst_issue_instr", o_issue_instr, 32'd0);
      chk("rst_rs1", {27'd0, o_rs1}, 32'd0);
      chk("rst_rs2", {27'd0, o_rs2}, 32'd0);
      chk("rst_fwd_a", {30'd0, o_fwd_a}, 32'd0);
      chk("rst_fwd_b", {30'd0, o_fwd_b}, 32'd0);
      chk("rst_stall_cnt", {16'd0, o_stall_cnt}, 32'd0);
      @(posedge i_clk); #1 i_rstn = 1'b1;

      // single ADD: issuable one cycle after accept
      send(ADD3, 5'd1, 5'd2, 2'd0, 2'd0);
      @(negedge i_clk);
      chk("t1_issue_valid", {31'd0, o_issue_valid}, 32'd1);
      idle(3);

      // back-to-back dependency forwards from EX
      send(ADD3, 5'd1, 5'd2, 2'd0, 2'd0);
      send(SUB4, 5'd3, 5'd1, 2'd1, 2'd0);
      idle(3);

      // one instruction in between: forward from MEM
      send(ADD3, 5'd1, 5'd2, 2'd0, 2'd0);
      send(ADDI8, 5'd0, 5'd0, 2'd0, 2'd0);
      send(SUB4, 5'd3, 5'd1, 2'd2, 2'd0);
      idle(3);

      // load-use: one stall cycle, then MEM forward
      send(LW5, 5'd1, 5'd0, 2'd0, 2'd0);
      send(ADD6, 5'd5, 5'd2, 2'd2, 2'd0);
      @(negedge i_clk);
      chk("t3_stall_issue_valid", {31'd0, o_issue_valid}, 32'd0);
      chk("t3_stall_instr_ready", {31'd0, o_instr_ready}, 32'd0);
      chk("t3_stall_cnt_before", {16'd0, o_stall_cnt}, exp_stall);
      exp_stall++;
      tick();
      @(negedge i_clk);
      chk("t3_stall_cnt_after", {16'd0, o_stall_cnt}, exp_stall);
      chk("t3_issue_valid", {31'd0, o_issue_valid}, 32'd1);
      idle(3);

      // writes to x0 never create hazards
      send(ADDI0, 5'd0, 5'd0, 2'd0, 2'd0);
      send(ADD7, 5'd0, 5'd0, 2'd0, 2'd0);
      @(negedge i_clk);
      chk("t4_issue_valid", {31'd0, o_issue_valid}, 32'd1);
      chk("t4_stall_cnt", {16'd0, o_stall_cnt}, exp_stall);
      idle(3);

      // downstream backpressure freezes buffer and shadows
      send(ADD3, 5'd1, 5'd2, 2'd0, 2'd0);
      send(SUB4, 5'd3, 5'd1, 2'd1, 2'd0);
      i_issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("t5_hold_issue_valid", {31'd0, o_issue_valid}, 32'd1);
         chk("t5_hold_instr_ready", {31'd0, o_instr_ready}, 32'd0);
         chk("t5_hold_fwd_a", {30'd0, o_fwd_a}, 32'd1);
         tick();
      end
      i_issue_ready = 1'b1;
      idle(3);

      // flush kills the buffered and the incoming instruction
      i_issue_ready = 1'b0;
      send(ADD3, 5'd1, 5'd2, 2'd0, 2'd0);
      i_flush = 1'b1; i_instr_valid = 1'b1; i_instr = ADDI8;
      @(negedge i_clk);
      chk("t6_flush_issue_valid", {31'd0, o_issue_valid}, 32'd0);
      chk("t6_flush_instr_ready", {31'd0, o_instr_ready}, 32'd0);
      tick();
      i_flush = 1'b0; i_instr_valid = 1'b0;
      @(negedge i_clk);
      chk("t6_after_issue_valid", {31'd0, o_issue_valid}, 32'd0);
      chk("t6_after_instr_ready", {31'd0, o_instr_ready}, 32'd1);
      void'(exp_q.pop_back());
      i_issue_ready = 1'b1;
      idle(3);

      // held load-use stall saturates the counter
      send(LW5, 5'd1, 5'd0, 2'd0, 2'd0);
      send(ADD6, 5'd5, 5'd2, 2'd2, 2'd0);
      i_issue_ready = 1'b0;
      repeat (10) tick();
      exp_stall += 10;
      @(negedge i_clk);
      chk("t7_stall_cnt_mid", {16'd0, o_stall_cnt}, exp_stall);
      chk("t7_issue_valid", {31'd0, o_issue_valid}, 32'd0);
      repeat ((1 << 16) + 5 - 10) tick();
      @(negedge i_clk);
      chk("t7_stall_cnt_sat", {16'd0, o_stall_cnt}, 32'h0000FFFF);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      void'(exp_q.pop_back());
      @(negedge i_clk);
      chk("t7_stall_cnt_hold", {16'd0, o_stall_cnt}, 32'h0000FFFF);
      i_issue_ready = 1'b1;
      idle(3);

      // asynchronous reset mid-operation
      i_issue_ready = 1'b0;
      send(ADD3, 5'd1, 5'd2, 2'd0, 2'd0);
      #1 i_rstn = 1'b0;
      #1;
      chk("t8_rst_issue_valid", {31'd0, o_issue_valid}, 32'd0);
      chk("t8_rst_instr_ready", {31'd0, o_instr_ready}, 32'd1);
      chk("t8_rst_issue_instr", o_issue_instr, 32'd0);
      chk("t8_rst_stall_cnt", {16'd0, o_stall_cnt}, 32'd0);
      void'(exp_q.pop_back());
      @(posedge i_clk); #1 i_rstn = 1'b1;
      i_issue_ready = 1'b1;
      idle(2);

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
- Sequences instructions from fetch into the decode/execute datapath.
- Buffers one instruction and detects RAW hazards against shadow copies of the EX and MEM stages.
- Stalls on load-use hazards and drives per-operand forwarding selects and register-file read addresses.
- Sits between the fetch queue and the decode/register-read stage; owns the issue handshake.

Parameters:
- CNT_W, 16, width of the saturating stall performance counter.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_instr_valid  in  1  upstream instruction valid.
- i_instr  in  32  upstream instruction word.
- o_instr_ready  out  1  controller accepts i_instr this cycle.
- o_issue_valid  out  1  o_issue_instr is issuable this cycle.
- i_issue_ready  in  1  downstream pipeline advances this cycle.
- o_issue_instr  out  32  buffered instruction being issued.
- o_rs1  out  5  register-file read address, port 1.
- o_rs2  out  5  register-file read address, port 2.
- o_fwd_a  out  2  operand-1 source: 0 = regfile, 1 = EX result, 2 = MEM result.
- o_fwd_b  out  2  operand-2 source, same encoding as o_fwd_a.
- i_flush  in  1  branch/jump redirect; kill buffered and incoming instruction.
- o_stall_cnt  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Reset (asynchronous, i_rstn low):
  - Buffer valid_q = 0; EX and MEM shadows invalid; o_stall_cnt = 0.
  - o_issue_valid = 0, o_instr_ready = 1, o_issue_instr = 0, o_rs1 = o_rs2 = 0, o_fwd_a = o_fwd_b = 0.
- Opcode classes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, JAL 1101111, LUI 0110111, AUIPC 0010111.
- Register usage:
  - uses_rs1 for R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 for R, STORE, BRANCH.
  - writes_rd for R, I-ALU, LOAD, JALR, JAL, LUI, AUIPC, and only when rd != 0.
  - Unknown opcodes use and write nothing; they issue with no hazard checks.
- o_rs1/o_rs2 = instr_q[19:15] / [24:20] when the corresponding uses_* is set, else 0. Combinational from the buffer.
- Buffer:
  - o_instr_ready = !i_flush && (!valid_q || issue_fire).
  - Accept when i_instr_valid && o_instr_ready: instr_q <= i_instr, valid_q <= 1.
  - If issue_fire occurs without an accept, valid_q <= 0.
  - Latency from accept to earliest issue is 1 cycle.
- Load-use hazard: EX shadow valid && is_load && ex_rd equals a used source register (rd != 0).
- Issue:
  - o_issue_valid = valid_q && !load_use && !i_flush.
  - issue_fire = o_issue_valid && i_issue_ready.
- Forwarding, per used source rs:
  - 1 if the EX shadow is valid, writes_rd, and ex_rd == rs.
  - Else 2 if the MEM shadow is valid, writes_rd, and mem_rd == rs.
  - Else 0.
  - EX has priority over MEM. rs == 0 or an unused source always gives 0.
- Shadows advance only when i_issue_ready = 1:
  - MEM <= EX.
  - EX <= {issue_fire, rd, is_load, writes_rd} of the issued instruction, or a bubble if nothing fired.
  - With i_issue_ready = 0, both shadows hold.
- Flush:
  - valid_q <= 0; no accept that cycle; no issue that cycle.
  - Shadows advance normally; a bubble enters EX.
  - Flush has priority over everything except reset.
- Stall counter increments when valid_q && load_use && !i_flush; it saturates at all-ones.
- Reset mid-operation discards the buffer and shadows immediately.

Test Plan:
- Reset release, then issue ADD x3,x1,x2 (0x002081B3) with i_issue_ready = 1:
  - Accepted in cycle 0; o_issue_valid = 1 in cycle 1.
  - o_rs1 = 1, o_rs2 = 2, fwd_a = fwd_b = 0.
- ADD x3,x1,x2 then SUB x4,x3,x1 (0x40118233) back-to-back:
  - SUB issues the next cycle with fwd_a = 1, fwd_b = 0.
  - Insert one independent instruction between them instead → SUB gets fwd_a = 2.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x2:
  - ADD is held one cycle (o_issue_valid = 0, o_instr_ready = 0, o_stall_cnt 0 → 1).
  - ADD then issues with fwd_a = 2.
- Writes to x0: ADDI x0,x0,1 then ADD x7,x0,x0 → no stall, fwd_a = fwd_b = 0.
- i_issue_ready = 0 for 3 cycles with an instruction buffered:
  - o_issue_valid stays 1 and o_instr_ready stays 0.
  - Shadows freeze; forwarding selects are unchanged when ready returns.
- i_flush asserted with valid_q = 1 and i_instr_valid = 1:
  - Next cycle valid_q = 0; the incoming instruction is not accepted.
  - o_issue_valid = 0 during the flush cycle.
- Drive a continuous load-use stall for 2^CNT_W + 5 cycles → o_stall_cnt holds at all-ones.
